// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, issues 16-bit reads over a req/ack port
// and buffers returned words with their PCs in a 2-entry queue ahead of the decoder.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_INC   = 16'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [15:0] instr_out,
  output logic [15:0] pc_out,
  output logic        instr_valid,
  output logic [1:0]  dbgState
);

  // Memory handshake: mem_req rises and mem_addr is held constant until the cycle
  // mem_ack is sampled high on a rising edge; that edge both accepts the request and
  // captures mem_rdata. mem_ack is ignored whenever mem_req is low.

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DROP = 2'd2} state_t;

  localparam logic [15:0] BOOT_PC = RESET_PC & 16'hFFFE;

  state_t      state;
  logic [15:0] fetchPc;
  logic [15:0] reqAddr;
  logic [1:0]  count;
  logic [15:0] instr0, instr1, pc0, pc1;

  logic        pop, push, space;
  logic [1:0]  countNext, countAfterPop;
  logic [15:0] targetPc;

  always_comb begin
    targetPc      = redirect_pc & 16'hFFFE;
    pop           = en && (count != 2'd0);
    push          = (state == REQ) && mem_ack && !redirect;
    countAfterPop = count - {1'b0, pop};
    countNext     = countAfterPop + {1'b0, push};
    space         = (countNext < 2'd2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      fetchPc <= BOOT_PC;
      reqAddr <= BOOT_PC;
      count   <= 2'd0;
      instr0  <= 16'h0000;
      instr1  <= 16'h0000;
      pc0     <= 16'h0000;
      pc1     <= 16'h0000;
    end else begin
      // Slot 0 is always the head; a push lands in the first slot left free after the pop.
      if (redirect) begin
        count <= 2'd0;
      end else begin
        count <= countNext;
        if (pop) begin
          instr0 <= instr1;
          pc0    <= pc1;
        end
        if (push) begin
          if (countAfterPop == 2'd0) begin
            instr0 <= mem_rdata;
            pc0    <= reqAddr;
          end else begin
            instr1 <= mem_rdata;
            pc1    <= reqAddr;
          end
        end
      end

      case (state)
        IDLE: begin
          if (redirect) begin
            state   <= REQ;
            reqAddr <= targetPc;
          end else if (space) begin
            state   <= REQ;
            reqAddr <= fetchPc;
          end
        end
        REQ: begin
          if (mem_ack && !redirect) begin
            fetchPc <= reqAddr + PC_INC;
            if (space) reqAddr <= reqAddr + PC_INC;
            else       state   <= IDLE;
          end else if (mem_ack) begin
            fetchPc <= targetPc + PC_INC;
            reqAddr <= targetPc;
          end else if (redirect) begin
            // The outstanding address must stay on the bus; remember the target instead.
            fetchPc <= targetPc;
            state   <= DROP;
          end
        end
        DROP: begin
          if (redirect) fetchPc <= targetPc;
          if (mem_ack) begin
            state   <= REQ;
            reqAddr <= redirect ? targetPc : fetchPc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_req     = (state != IDLE);
    mem_addr    = reqAddr;
    instr_valid = (count != 2'd0);
    instr_out   = instr_valid ? instr0 : 16'h0000;
    pc_out      = instr_valid ? pc0 : fetchPc;
    dbgState    = state;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based reference model.
module tb_fetch_stage;

  localparam logic [15:0] RST_PC = 16'h0100;
  localparam logic [15:0] INC    = 16'd2;

  logic        clk, rst, en, redirect, mem_ack;
  logic [15:0] redirect_pc, mem_rdata;
  logic        mem_req, instr_valid;
  logic [15:0] mem_addr, instr_out, pc_out;
  logic [1:0]  dbgState;

  fetch_stage #(.RESET_PC(RST_PC), .PC_INC(INC)) dut (
    .clk(clk), .rst(rst), .en(en), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr_out(instr_out), .pc_out(pc_out), .instr_valid(instr_valid), .dbgState(dbgState)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int nChecks = 0;
  int nFail   = 0;
  bit xorData = 1'b1;

  // Reference model: the fetched-but-unconsumed words as a plain queue, plus the
  // bookkeeping of the single outstanding read.
  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
  } ent_t;
  ent_t        mq[$];
  bit          mOut;    // a read is on the bus
  bit          mStale;  // that read was overtaken by a redirect; its data is thrown away
  logic [15:0] mAddr;
  logic [15:0] mNextPc;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    mOut    = 1'b0;
    mStale  = 1'b0;
    mAddr   = RST_PC & 16'hFFFE;
    mNextPc = RST_PC & 16'hFFFE;
  endtask

  task automatic modelEdge();
    bit          pop, push, room;
    int          sz;
    logic [15:0] rp, oldAddr;
    if (rst) begin
      modelReset();
      return;
    end
    rp      = redirect_pc & 16'hFFFE;
    oldAddr = mAddr;
    pop     = en && (mq.size() != 0);
    push    = mOut && !mStale && mem_ack && !redirect;
    sz      = mq.size() + int'(push) - int'(pop);
    room    = (sz < 2);

    if (!mOut) begin
      if (redirect) begin
        mOut = 1'b1; mAddr = rp;
      end else if (room) begin
        mOut = 1'b1; mAddr = mNextPc;
      end
    end else if (!mStale) begin
      if (mem_ack && !redirect) begin
        mNextPc = oldAddr + INC;
        if (room) mAddr = oldAddr + INC;
        else      mOut  = 1'b0;
      end else if (mem_ack) begin
        mNextPc = rp + INC;
        mAddr   = rp;
      end else if (redirect) begin
        mStale  = 1'b1;
        mNextPc = rp;
      end
    end else begin
      if (mem_ack) begin
        mStale = 1'b0;
        mAddr  = redirect ? rp : mNextPc;
      end
      if (redirect) mNextPc = rp;
    end

    if (redirect) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back('{instr: mem_rdata, pc: oldAddr});
    end
  endtask

  task automatic compareAll();
    logic        expValid;
    logic [15:0] expInstr, expPc;
    expValid = (mq.size() != 0);
    expInstr = expValid ? mq[0].instr : 16'h0000;
    expPc    = expValid ? mq[0].pc : mNextPc;
    chk("mdl_mem_req", {15'd0, mem_req}, {15'd0, mOut});
    chk("mdl_mem_addr", mem_addr, mAddr);
    chk("mdl_instr_valid", {15'd0, instr_valid}, {15'd0, expValid});
    chk("mdl_instr_out", instr_out, expInstr);
    chk("mdl_pc_out", pc_out, expPc);
  endtask

  // One clock: present read data, let the edge happen, then check on the falling edge.
  task automatic step();
    if (xorData) mem_rdata = mem_addr ^ 16'hA5A5;
    else         mem_rdata = 16'($urandom);
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    compareAll();
  endtask

  task automatic chkResetValues(input string tag);
    chk({tag, "_req"}, {15'd0, mem_req}, 16'd0);
    chk({tag, "_addr"}, mem_addr, RST_PC);
    chk({tag, "_valid"}, {15'd0, instr_valid}, 16'd0);
    chk({tag, "_instr"}, instr_out, 16'h0000);
    chk({tag, "_pc"}, pc_out, RST_PC);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    modelReset();
    @(negedge clk);
    step();
    step();
    chkResetValues("reset");

    // Streaming with zero-wait memory: one instruction per cycle.
    rst = 1'b0; en = 1'b1; mem_ack = 1'b1;
    step();
    chk("t1_addr0", mem_addr, 16'h0100);
    chk("t1_req", {15'd0, mem_req}, 16'd1);
    step();
    chk("t1_addr1", mem_addr, 16'h0102);
    chk("t1_valid", {15'd0, instr_valid}, 16'd1);
    chk("t1_pc0", pc_out, 16'h0100);
    chk("t1_instr0", instr_out, 16'hA4A5);
    step();
    chk("t1_addr2", mem_addr, 16'h0104);
    chk("t1_pc1", pc_out, 16'h0102);

    // Decoder stalled: queue fills to two and fetching stops.
    rst = 1'b1; step();
    rst = 1'b0; en = 1'b0; mem_ack = 1'b1;
    repeat (5) step();
    chk("t2_req_off", {15'd0, mem_req}, 16'd0);
    chk("t2_hold_instr", instr_out, 16'hA4A5);
    chk("t2_hold_pc", pc_out, 16'h0100);
    en = 1'b1;
    step();
    chk("t2_reissue_req", {15'd0, mem_req}, 16'd1);
    chk("t2_reissue_addr", mem_addr, 16'h0104);
    chk("t2_order_pc", pc_out, 16'h0102);

    // Redirect while a read waits for its ack: stale address held, data dropped.
    mem_ack = 1'b0;
    step();
    redirect = 1'b1; redirect_pc = 16'h0400;
    step();
    redirect = 1'b0;
    step();
    step();
    chk("t3_stale_addr", mem_addr, 16'h0104);
    chk("t3_stale_req", {15'd0, mem_req}, 16'd1);
    chk("t3_flushed", {15'd0, instr_valid}, 16'd0);
    mem_ack = 1'b1;
    step();
    chk("t3_new_addr", mem_addr, 16'h0400);
    chk("t3_drop_valid", {15'd0, instr_valid}, 16'd0);
    step();
    chk("t3_first_pc", pc_out, 16'h0400);
    chk("t3_first_instr", instr_out, 16'hA1A5);

    // Redirect coinciding with an ack.
    redirect = 1'b1; redirect_pc = 16'h0200;
    step();
    redirect = 1'b0;
    chk("t4_addr", mem_addr, 16'h0200);
    chk("t4_valid", {15'd0, instr_valid}, 16'd0);
    step();
    chk("t4_pc", pc_out, 16'h0200);

    // Wrap of the 16-bit PC, with an odd target whose bit 0 must be cleared.
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    step();
    redirect = 1'b0;
    chk("t5_addr", mem_addr, 16'hFFFE);
    step();
    chk("t5_pc0", pc_out, 16'hFFFE);
    chk("t5_wrap_addr", mem_addr, 16'h0000);
    step();
    chk("t5_pc1", pc_out, 16'h0000);

    // Asynchronous reset with a full queue, between clock edges.
    en = 1'b0;
    step();
    step();
    chk("t6_full_valid", {15'd0, instr_valid}, 16'd1);
    chk("t6_full_req", {15'd0, mem_req}, 16'd0);
    #2 rst = 1'b1;
    #1 chkResetValues("t6_async");
    modelReset();
    step();
    rst = 1'b0;

    // Randomized traffic.
    xorData = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      en          = ($urandom_range(0, 3) != 0);
      mem_ack     = (i % 1000 < 200) ? 1'b1 : ($urandom_range(0, 2) != 0);
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = 16'($urandom);
      if ($urandom_range(0, 7) == 0) redirect_pc = 16'hFFFE | 16'($urandom_range(0, 1));
      rst         = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
